// File: rtl/bist_fail_logger.sv
// bist_fail_logger
// Capture stage behind the memory BIST comparator. Each enabled compare is
// checked against the expected pattern. The block keeps a sticky fail flag, a
// saturating failure count and an end-of-test verdict. The first DEPTH failing
// events are kept in a first-word-fall-through log that the host drains with
// rd_req.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   clear           synchronous start-of-run clear of log and status state
//   cmp_valid       compare strobe for cmp_addr/cmp_elem/mem_data/exp_data
//   cmp_addr        address of the compared word
//   cmp_elem        March element code for this read
//   mem_data        memory read data
//   exp_data        expected pattern
//   bist_done       one-cycle end-of-test pulse
//   rd_req          pop request for the head log entry
//   log_valid       head entry valid (log non-empty)
//   log_addr        head entry address
//   log_elem        head entry element code
//   log_syndrome    head entry mem_data ^ exp_data
//   log_count       number of entries held, 0..DEPTH
//   fail_any        sticky: at least one mismatch seen
//   fail_count      saturating mismatch count
//   overflow        sticky: a mismatch was dropped because the log was full
//   result_valid    sticky: bist_done seen
//   result_pass     verdict, valid with result_valid
module bist_fail_logger #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int ELEM_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       cmp_valid,
  input  logic [ADDR_W-1:0]          cmp_addr,
  input  logic [ELEM_W-1:0]          cmp_elem,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic                       bist_done,
  input  logic                       rd_req,
  output logic                       log_valid,
  output logic [ADDR_W-1:0]          log_addr,
  output logic [ELEM_W-1:0]          log_elem,
  output logic [DATA_W-1:0]          log_syndrome,
  output logic [$clog2(DEPTH):0]     log_count,
  output logic                       fail_any,
  output logic [CNT_W-1:0]           fail_count,
  output logic                       overflow,
  output logic                       result_valid,
  output logic                       result_pass
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LC_W  = PTR_W + 1;

  // Log storage; deliberately not reset, pointers and count define validity.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [ELEM_W-1:0] elem_mem [DEPTH];
  logic [DATA_W-1:0] syn_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              mismatch;
  logic [DATA_W-1:0] syndrome;
  logic              log_full;
  logic              log_empty;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;

  always_comb begin
    syndrome  = mem_data ^ exp_data;
    mismatch  = cmp_valid && (mem_data != exp_data);
    log_full  = (log_count == LC_W'(DEPTH));
    log_empty = (log_count == '0);
    do_pop    = rd_req && !log_empty;
    // A pop in the same cycle frees the slot a full log would otherwise lack.
    do_push   = mismatch && (!log_full || do_pop);
    do_drop   = mismatch && log_full && !do_pop;
  end

  // Storage write; events on reset/clear cycles are discarded.
  always_ff @(posedge clk) begin
    if (!reset && !clear && do_push) begin
      addr_mem[wr_ptr] <= cmp_addr;
      elem_mem[wr_ptr] <= cmp_elem;
      syn_mem[wr_ptr]  <= syndrome;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   log_count <= log_count + LC_W'(1);
        2'b01:   log_count <= log_count - LC_W'(1);
        default: log_count <= log_count;
      endcase
    end
  end

  // Status and verdict.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fail_any     <= 1'b0;
      fail_count   <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
    end else begin
      if (mismatch) begin
        fail_any <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
      end
      if (do_drop) overflow <= 1'b1;
      // Verdict is taken once per run; a coincident mismatch counts as a fail.
      if (bist_done && !result_valid) begin
        result_valid <= 1'b1;
        result_pass  <= !(fail_any || mismatch);
      end
    end
  end

  // First-word fall-through head.
  always_comb begin
    log_valid    = !log_empty;
    log_addr     = addr_mem[rd_ptr];
    log_elem     = elem_mem[rd_ptr];
    log_syndrome = syn_mem[rd_ptr];
  end

endmodule

// File: tb/tb_bist_fail_logger.sv
// Self-checking bench for bist_fail_logger: a queue-based reference model is
// compared against the DUT on every cycle, plus directed literal checks.
module tb_bist_fail_logger;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int ELEM_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [ELEM_W-1:0] cmp_elem;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] exp_data;
  logic              bist_done;
  logic              rd_req;
  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic [ELEM_W-1:0] log_elem;
  logic [DATA_W-1:0] log_syndrome;
  logic [$clog2(DEPTH):0] log_count;
  logic              fail_any;
  logic [CNT_W-1:0]  fail_count;
  logic              overflow;
  logic              result_valid;
  logic              result_pass;

  bist_fail_logger #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ELEM_W(ELEM_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_elem(cmp_elem),
    .mem_data(mem_data), .exp_data(exp_data), .bist_done(bist_done),
    .rd_req(rd_req), .log_valid(log_valid), .log_addr(log_addr),
    .log_elem(log_elem), .log_syndrome(log_syndrome), .log_count(log_count),
    .fail_any(fail_any), .fail_count(fail_count), .overflow(overflow),
    .result_valid(result_valid), .result_pass(result_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: log held as a queue of entries, status as plain ints.
  typedef struct {
    int a;
    int e;
    int s;
  } ent_t;

  ent_t q[$];
  int   m_cnt;
  bit   m_fail, m_ovf, m_rv, m_pass, m_mm;

  initial begin
    m_cnt = 0; m_fail = 0; m_ovf = 0; m_rv = 0; m_pass = 0;
  end

  always @(posedge clk) begin
    if (reset || clear) begin
      q.delete();
      m_cnt = 0; m_fail = 0; m_ovf = 0; m_rv = 0; m_pass = 0;
    end else begin
      m_mm = cmp_valid && (mem_data != exp_data);
      if (bist_done && !m_rv) begin
        m_rv = 1;
        m_pass = !(m_fail || m_mm);
      end
      if (rd_req && q.size() > 0) void'(q.pop_front());
      if (m_mm) begin
        ent_t n;
        n.a = int'(cmp_addr);
        n.e = int'(cmp_elem);
        n.s = int'(mem_data ^ exp_data);
        m_fail = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (q.size() < DEPTH) q.push_back(n);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("log_valid",    int'(log_valid),    int'(q.size() > 0));
    chk("log_count",    int'(log_count),    q.size());
    chk("fail_any",     int'(fail_any),     int'(m_fail));
    chk("fail_count",   int'(fail_count),   m_cnt);
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("result_valid", int'(result_valid), int'(m_rv));
    chk("result_pass",  int'(result_pass),  int'(m_pass));
    if (q.size() > 0) begin
      chk("log_addr",     int'(log_addr),     q[0].a);
      chk("log_elem",     int'(log_elem),     q[0].e);
      chk("log_syndrome", int'(log_syndrome), q[0].s);
    end
  end

  task automatic idle();
    clear = 0; cmp_valid = 0; cmp_addr = '0; cmp_elem = '0;
    mem_data = '0; exp_data = '0; bist_done = 0; rd_req = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One cycle of stimulus, then back to idle inputs.
  task automatic cyc(input bit v, input int a, input int e, input int m,
                     input int x, input bit rd, input bit bd);
    cmp_valid = v; cmp_addr = ADDR_W'(a); cmp_elem = ELEM_W'(e);
    mem_data = DATA_W'(m); exp_data = DATA_W'(x); rd_req = rd; bist_done = bd;
    step();
    idle();
  endtask

  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  task automatic status_zero(input string tag);
    chk({tag, "_log_valid"},  int'(log_valid),    0);
    chk({tag, "_log_count"},  int'(log_count),    0);
    chk({tag, "_fail_any"},   int'(fail_any),     0);
    chk({tag, "_fail_count"}, int'(fail_count),   0);
    chk({tag, "_overflow"},   int'(overflow),     0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_result_pass"},  int'(result_pass),  0);
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    status_zero("reset");

    // Clean run.
    for (int i = 0; i < 128; i++) begin
      int d;
      d = (i % 2 == 0) ? 8'h00 : 8'hFF;
      cyc(1, i % 32, i % 6, d, d, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("clean_fail_any", int'(fail_any), 0);
    chk("clean_fail_count", int'(fail_count), 0);
    chk("clean_log_valid", int'(log_valid), 0);
    chk("clean_result_valid", int'(result_valid), 1);
    chk("clean_result_pass", int'(result_pass), 1);

    // Single fault.
    do_clear();
    cyc(1, 5, 4, 8'hFB, 8'hFF, 0, 0);
    chk("single_log_valid", int'(log_valid), 1);
    chk("single_log_addr", int'(log_addr), 5);
    chk("single_log_elem", int'(log_elem), 4);
    chk("single_syndrome", int'(log_syndrome), 8'h04);
    chk("single_fail_count", int'(fail_count), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("single_pop_valid", int'(log_valid), 0);

    // Overflow.
    do_clear();
    for (int i = 0; i < 6; i++) cyc(1, i, 1, 8'h55, 8'hAA, 0, 0);
    chk("ovf_log_count", int'(log_count), 4);
    chk("ovf_overflow", int'(overflow), 1);
    chk("ovf_fail_count", int'(fail_count), 6);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_addr", int'(log_addr), i);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    chk("ovf_drained", int'(log_valid), 0);

    // Full push + pop.
    do_clear();
    for (int i = 0; i < 4; i++) cyc(1, 10 + i, 2, 8'h0F, 8'h00, 0, 0);
    cyc(1, 9, 3, 8'h80, 8'h00, 1, 0);
    chk("pp_log_count", int'(log_count), 4);
    chk("pp_overflow", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      int ea;
      ea = (i < 3) ? 11 + i : 9;
      chk("pp_drain_addr", int'(log_addr), ea);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    chk("pp_drained", int'(log_valid), 0);

    // Saturation and coincident mismatch on bist_done.
    do_clear();
    for (int i = 0; i < 300; i++) cyc(1, i % 32, 5, 8'h01, 8'h00, 0, 0);
    chk("sat_fail_count", int'(fail_count), 255);
    do_clear();
    cyc(1, 7, 6, 8'h10, 8'h00, 0, 1);
    chk("coinc_result_valid", int'(result_valid), 1);
    chk("coinc_result_pass", int'(result_pass), 0);
    chk("coinc_fail_count", int'(fail_count), 1);

    // Mid-run clear and reset with a coincident mismatch.
    do_clear();
    for (int i = 0; i < 3; i++) cyc(1, i, 7, 8'h33, 8'h00, 0, 0);
    clear = 1;
    cyc(1, 20, 7, 8'hFF, 8'h00, 0, 0);
    status_zero("midclear");
    for (int i = 0; i < 3; i++) cyc(1, i, 7, 8'h33, 8'h00, 0, 0);
    reset = 1;
    cyc(1, 20, 7, 8'hFF, 8'h00, 0, 0);
    reset = 0;
    status_zero("midreset");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int x, m;
      x = int'($urandom_range(0, 255));
      m = ($urandom_range(0, 3) == 0) ? (x ^ int'($urandom_range(1, 255))) : x;
      clear = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 399) == 0);
      cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
          int'($urandom_range(0, 15)), m, x,
          $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
      reset = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_fail_logger.md
# bist_fail_logger

Diagnostic capture stage directly downstream of the BIST comparator in the 32x8 March-Y memory BIST datapath. On every enabled compare it checks the delayed memory read data against the expected pattern and keeps a sticky pass/fail verdict and a saturating failure count. It also stores the first DEPTH failing events (address, March element, bit syndrome) in a first-word-fall-through log that the host drains with a pop handshake.

## Interface
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 8, memory word width
- ELEM_W, 4, March element / controller state code width
- DEPTH, 4, log entries; power of two, minimum 2
- CNT_W, 8, failure counter width
- clk  in  1  clock; all state on rising edge
- reset  in  1  reset, synchronous, active-high
- clear  in  1  synchronous start-of-run clear of all log and status state
- cmp_valid  in  1  compare strobe, aligned with mem_data/exp_data/cmp_addr/cmp_elem
- cmp_addr  in  ADDR_W  address of the word being compared
- cmp_elem  in  ELEM_W  March element code active for this read
- mem_data  in  DATA_W  memory read data
- exp_data  in  DATA_W  expected pattern
- bist_done  in  1  one-cycle end-of-test pulse
- rd_req  in  1  pop request for the head log entry
- log_valid  out  1  log non-empty; head entry valid
- log_addr  out  ADDR_W  head entry address
- log_elem  out  ELEM_W  head entry element code
- log_syndrome  out  DATA_W  head entry mem_data XOR exp_data
- log_count  out  clog2(DEPTH)+1  entries held
- fail_any  out  1  sticky: at least one mismatch since clear/reset
- fail_count  out  CNT_W  mismatches since clear/reset, saturating
- overflow  out  1  sticky: a mismatch was dropped because the log was full
- result_valid  out  1  sticky: bist_done seen since clear/reset
- result_pass  out  1  valid with result_valid: 1 = no mismatch in the run

## Operation
- Mismatch event: cmp_valid=1 and mem_data != exp_data. Syndrome = mem_data ^ exp_data. Never nonzero without a mismatch.
- Each mismatch: fail_any <= 1; fail_count += 1, holding at 2^CNT_W-1 (no wrap).
- Log push: on a mismatch, write {cmp_elem, cmp_addr, syndrome} at the write pointer if not full. If full and no pop in the same cycle, drop the entry and set overflow <= 1.
- Log pop: rd_req=1 with log_valid=1 advances the read pointer. rd_req with log empty is ignored.
- Simultaneous push and pop when full: both happen, count unchanged, no overflow.
- Simultaneous push and pop when empty: the push happens and the pop is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. log_count is tracked separately, range 0..DEPTH.
- Entries are stored in arrival order and read out FIFO.
- bist_done pulse: result_valid <= 1; result_pass <= ~(fail_any | mismatch in the same cycle). A mismatch coincident with bist_done is included in the verdict.
- Mismatches after result_valid still update the log and counters. result_pass is frozen until the next clear.
- Priority: reset > clear > normal operation.
- clear and reset both zero the pointers, log_count, fail_any, fail_count, overflow, result_valid and result_pass. Events arriving on a clear cycle are discarded.
- Storage contents are not reset. The head output fields are don't-care while log_valid=0; the bench must not check them.

## Timing
- Reset values: log_valid=0, log_count=0, fail_any=0, fail_count=0, overflow=0, result_valid=0, result_pass=0.
- Mismatch in cycle N: fail_any, fail_count, log_count and log_valid update at the N+1 edge and are visible in cycle N+1.
- First-word fall-through: head fields are driven from storage at the read pointer. An entry pushed into an empty log appears in cycle N+1.
- Pop in cycle N: the next entry (or log_valid=0) is visible in cycle N+1.
- bist_done in cycle N: result_valid and result_pass are visible in cycle N+1.
- Throughput: one event and one pop per cycle; no back-pressure to the comparator.
- Reset or clear asserted mid-run takes effect at the next edge, with no partial entry left behind.

## Test plan
- Clean run: 128 compares with mem_data==exp_data (0x00/0xFF), then bist_done -> fail_any=0, fail_count=0, log_valid=0, result_valid=1, result_pass=1.
- Single fault: mismatch at addr 5, elem 4, mem 0xFB, exp 0xFF -> next cycle log_valid=1, log_addr=5, log_elem=4, log_syndrome=0x04, fail_count=1. Pop -> log_valid=0.
- Overflow: 6 consecutive mismatches at addrs 0..5 with DEPTH=4, no pops -> log_count=4, overflow=1, fail_count=6. Drain returns addrs 0,1,2,3 in order.
- Full push+pop: log full; in one cycle assert a mismatch at addr 9 with rd_req -> log_count stays 4, overflow stays 0, and addr 9 is the last entry drained.
- Saturation and coincidence: 300 mismatches with CNT_W=8 -> fail_count=255. After clear, a single mismatch on the bist_done cycle -> result_pass=0, fail_count=1.
- Mid-run clear/reset: with 3 entries logged, assert clear together with a mismatch -> next cycle every status output is zero and log_valid=0. Repeat with reset and get the same result.
